// File: rtl/carregador_pkg.sv
// carregador_pkg -- shared definitions for the program loader.
//   estadoT             : loader FSM state encoding
//   ADDR_WIDTH_PADRAO   : default RAM address width
//   DATA_WIDTH_PADRAO   : default RAM word width
//   RAM_DEPTH           : number of words in the default RAM
package carregador_pkg;

  localparam int ADDR_WIDTH_PADRAO = 4;
  localparam int DATA_WIDTH_PADRAO = 8;
  localparam int RAM_DEPTH         = 2 ** ADDR_WIDTH_PADRAO;

  typedef enum logic [1:0] {
    OCIOSO      = 2'd0,
    CARREGANDO  = 2'd1,
    VERIFICANDO = 2'd2,
    CONCLUIDO   = 2'd3
  } estadoT;

endpackage

// File: rtl/sincroniza_borda.sv
// sincroniza_borda -- two-flop synchronizer plus rising-edge detector for a
// raw asynchronous input (key or switch).
//   clock   : system clock
//   resetn  : asynchronous active-low reset, clears all three flops
//   entrada : raw asynchronous input
//   borda   : one-cycle pulse when the synchronized input goes 0 -> 1
module sincroniza_borda (
  input  logic clock,
  input  logic resetn,
  input  logic entrada,
  output logic borda
);

  logic s1;
  logic s2;
  logic prev;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= entrada;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign borda = s2 & ~prev;

endmodule

// File: rtl/carregador_ram.sv
// carregador_ram -- fills the processor RAM from the switch bank, one byte
// per strobe, at an auto-incrementing address.
//   Clock    : system clock
//   Resetn   : asynchronous active-low reset
//   Dados    : byte to store (switches)
//   Strobe   : raw write request, synchronized internally
//   Inicio   : one-cycle pulse, (re)starts a load at address 0
//   Fim      : when high at a strobe edge, ends the load without writing
//   MemQ     : RAM read data (1-cycle latency), used only by readback verify
//   MemAddr  : RAM address
//   MemData  : RAM write data
//   MemWrite : one-cycle RAM write enable
//   Contagem : words written in the current load (0..depth)
//   Ocupado  : load in progress
//   Pronto   : load finished, processor may run
//   Erro     : sticky readback mismatch
// Optional build macro CARREGADOR_VERIFICA_EN adds a readback check of every
// written word; without it MemQ is ignored and Erro is constant 0.
module carregador_ram
  import carregador_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_PADRAO,
  parameter int DATA_WIDTH = DATA_WIDTH_PADRAO
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic [DATA_WIDTH-1:0] Dados,
  input  logic                  Strobe,
  input  logic                  Inicio,
  input  logic                  Fim,
  input  logic [DATA_WIDTH-1:0] MemQ,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [DATA_WIDTH-1:0] MemData,
  output logic                  MemWrite,
  output logic [ADDR_WIDTH:0]   Contagem,
  output logic                  Ocupado,
  output logic                  Pronto,
  output logic                  Erro
);

  localparam int PROFUNDIDADE = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CONTAGEM_MAX = (ADDR_WIDTH + 1)'(PROFUNDIDADE);

  logic borda;

  estadoT                estado,      estadoProx;
  logic [ADDR_WIDTH:0]   contagem,    contagemProx;
  logic [ADDR_WIDTH-1:0] endereco,    enderecoProx;
  logic [DATA_WIDTH-1:0] dado,        dadoProx;
  logic                  escrita,     escritaProx;
  logic                  erro,        erroProx;
  logic                  passo,       passoProx;

  sincroniza_borda uSincroniza (
    .clock   (Clock),
    .resetn  (Resetn),
    .entrada (Strobe),
    .borda   (borda)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      estado   <= OCIOSO;
      contagem <= '0;
      endereco <= '0;
      dado     <= '0;
      escrita  <= 1'b0;
      erro     <= 1'b0;
      passo    <= 1'b0;
    end else begin
      estado   <= estadoProx;
      contagem <= contagemProx;
      endereco <= enderecoProx;
      dado     <= dadoProx;
      escrita  <= escritaProx;
      erro     <= erroProx;
      passo    <= passoProx;
    end
  end

  always_comb begin
    estadoProx   = estado;
    contagemProx = contagem;
    enderecoProx = endereco;
    dadoProx     = dado;
    escritaProx  = 1'b0;
    erroProx     = erro;
    passoProx    = passo;

    // Inicio has priority over everything, including a coincident edge.
    if (Inicio) begin
      estadoProx   = CARREGANDO;
      contagemProx = '0;
      enderecoProx = '0;
      erroProx     = 1'b0;
      passoProx    = 1'b0;
    end else begin
      case (estado)
        CARREGANDO: begin
`ifdef CARREGADOR_VERIFICA_EN
          if (escrita) begin
            // Write cycle just ended: read the word back before accepting more.
            estadoProx = VERIFICANDO;
            passoProx  = 1'b0;
          end else
`else
          // Completion is deferred by one cycle so Pronto follows the last
          // write cycle instead of overlapping it.
          if (escrita && contagem == CONTAGEM_MAX) begin
            estadoProx = CONCLUIDO;
          end else
`endif
          if (borda) begin
            if (Fim) begin
              estadoProx = CONCLUIDO;
            end else begin
              // Contagem equals the next free address while below the depth.
              enderecoProx = contagem[ADDR_WIDTH-1:0];
              dadoProx     = Dados;
              escritaProx  = 1'b1;
              contagemProx = contagem + 1'b1;
            end
          end
        end
`ifdef CARREGADOR_VERIFICA_EN
        VERIFICANDO: begin
          // First cycle presents the address, MemQ is valid on the second.
          if (!passo) begin
            passoProx = 1'b1;
          end else begin
            passoProx = 1'b0;
            if (MemQ != dado) erroProx = 1'b1;
            estadoProx = (contagem == CONTAGEM_MAX) ? CONCLUIDO : CARREGANDO;
          end
        end
`endif
        default: ;  // OCIOSO and CONCLUIDO ignore strobe edges
      endcase
    end
  end

  assign MemAddr  = endereco;
  assign MemData  = dado;
  assign MemWrite = escrita;
  assign Contagem = contagem;
  assign Ocupado  = (estado == CARREGANDO) || (estado == VERIFICANDO);
  assign Pronto   = (estado == CONCLUIDO);

`ifdef CARREGADOR_VERIFICA_EN
  assign Erro = erro;
`else
  assign Erro = 1'b0;
  logic unusedMemQ;
  assign unusedMemQ = ^MemQ;
`endif

endmodule

// File: tb/tb_carregador_ram.sv
// tb_carregador_ram -- randomized scoreboard bench for carregador_ram.
// The stimulus side keeps a plain model of the load (active flag, word count,
// finished flag) and pushes every write it expects; a monitor pops and
// compares on every MemWrite cycle.
module tb_carregador_ram;
  import carregador_pkg::*;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic [7:0] Dados = 8'h00;
  logic       Strobe = 1'b0;
  logic       Inicio = 1'b0;
  logic       Fim = 1'b0;
  logic [7:0] MemQ = 8'h00;
  logic [3:0] MemAddr;
  logic [7:0] MemData;
  logic       MemWrite;
  logic [4:0] Contagem;
  logic       Ocupado;
  logic       Pronto;
  logic       Erro;

  carregador_ram dut (
    .Clock(Clock), .Resetn(Resetn), .Dados(Dados), .Strobe(Strobe),
    .Inicio(Inicio), .Fim(Fim), .MemQ(MemQ), .MemAddr(MemAddr),
    .MemData(MemData), .MemWrite(MemWrite), .Contagem(Contagem),
    .Ocupado(Ocupado), .Pronto(Pronto), .Erro(Erro)
  );

  always #5 Clock = ~Clock;

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    int addr;
    int data;
    int cont;
    int when;
  } escritaT;
  escritaT fila[$];

  // Reference model of the load.
  bit carregando = 0;
  bit concluido  = 0;
  int nPalavras  = 0;
  bit erroExp    = 0;
  bit corromper  = 0;

  // Simple RAM so the readback path sees real data.
  logic [7:0] ram [RAM_DEPTH];
  always @(posedge Clock) begin
    if (MemWrite) ram[MemAddr] <= MemData;
    MemQ <= corromper ? 8'h00 : ram[MemAddr];
  end

  task automatic verifica(input string nome, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nome, act, exp, $time);
    end
  endtask

  always @(negedge Clock) begin
    if (Resetn && MemWrite) begin
      if (fila.size() == 0) begin
        verifica("unexpected MemWrite", 1, 0);
      end else begin
        escritaT e;
        e = fila.pop_front();
        $display("write addr=%0d data=%02h contagem=%0d cyc=%0d", MemAddr, MemData, Contagem, cyc);
        verifica("MemAddr", int'(MemAddr), e.addr);
        verifica("MemData", int'(MemData), e.data);
        verifica("Contagem at write", int'(Contagem), e.cont);
        verifica("write cycle", cyc, e.when);
      end
    end
  end

  task automatic checaEstado(input string nome);
    verifica({nome, " Contagem"}, int'(Contagem), nPalavras);
    verifica({nome, " Pronto"}, int'(Pronto), int'(concluido));
    verifica({nome, " Ocupado"}, int'(Ocupado), int'(carregando));
    verifica({nome, " Erro"}, int'(Erro), int'(erroExp));
  endtask

  task automatic inicio();
    @(negedge Clock);
    Inicio = 1'b1;
    carregando = 1; concluido = 0; nPalavras = 0; erroExp = 0;
    @(negedge Clock);
    Inicio = 1'b0;
    checaEstado("after Inicio");
  endtask

  // One strobe: high for h cycles, low for l cycles.
  task automatic pulso(input logic [7:0] d, input bit f, input int h, input int l);
    @(negedge Clock);
    Dados = d; Fim = f; Strobe = 1'b1;
    if (carregando) begin
      if (f) begin
        carregando = 0; concluido = 1;
      end else begin
        fila.push_back('{nPalavras, int'(d), nPalavras + 1, cyc + 3});
`ifdef CARREGADOR_VERIFICA_EN
        if (corromper) erroExp = 1;
`endif
        nPalavras++;
        if (nPalavras == RAM_DEPTH) begin
          carregando = 0; concluido = 1;
        end
      end
    end
    repeat (h) @(negedge Clock);
    Strobe = 1'b0;
    repeat (l) @(negedge Clock);
    Fim = 1'b0;
    verifica("write drained", fila.size(), 0);
    checaEstado("after strobe");
  endtask

  task automatic pulsoAleatorio(input logic [7:0] d, input bit f);
    pulso(d, f, $urandom_range(3, 8), $urandom_range(3, 5));
  endtask

  initial begin
    repeat (3) @(negedge Clock);
    verifica("reset MemAddr", int'(MemAddr), 0);
    verifica("reset MemData", int'(MemData), 0);
    verifica("reset MemWrite", int'(MemWrite), 0);
    checaEstado("reset");
    Resetn = 1'b1;

    // Idle: strobes are ignored.
    pulsoAleatorio(8'h77, 0);

    // Full load of 16 words.
    inicio();
    for (int i = 0; i < 16; i++) pulsoAleatorio(8'h10 + 8'(i), 0);

    // Finished: strobes ignored.
    pulsoAleatorio(8'h99, 0);

    // Restart, one long strobe gives exactly one write, then Fim ends early.
    inicio();
    pulso(8'($urandom), 0, 20, 4);
    inicio();
    pulsoAleatorio(8'hA1, 0);
    pulsoAleatorio(8'hB2, 0);
    pulsoAleatorio(8'hC3, 0);
    pulsoAleatorio(8'hD4, 1);
    pulsoAleatorio(8'hE5, 0);

    // Random loads with occasional Fim.
    for (int r = 0; r < 3; r++) begin
      inicio();
      for (int i = 0; i < 10; i++) pulsoAleatorio(8'($urandom), ($urandom_range(0, 5) == 0));
    end

    // Asynchronous reset in the middle of a load.
    inicio();
    for (int i = 0; i < 5; i++) pulsoAleatorio(8'($urandom), 0);
    @(negedge Clock);
    #2 Resetn = 1'b0;
    carregando = 0; concluido = 0; nPalavras = 0; erroExp = 0;
    #1;
    verifica("async reset MemAddr", int'(MemAddr), 0);
    verifica("async reset MemData", int'(MemData), 0);
    checaEstado("async reset");
    @(negedge Clock);
    Resetn = 1'b1;
    pulsoAleatorio(8'h3C, 0);
    pulsoAleatorio(8'h4D, 0);

`ifdef CARREGADOR_VERIFICA_EN
    // Readback: a corrupted word sets Erro, it sticks, Inicio clears it.
    inicio();
    pulsoAleatorio(8'h11, 0);
    corromper = 1;
    pulsoAleatorio(8'h5A, 0);
    corromper = 0;
    pulsoAleatorio(8'h22, 0);
    pulsoAleatorio(8'h33, 0);
    inicio();
    pulsoAleatorio(8'h44, 0);
`endif

    repeat (10) @(negedge Clock);
    verifica("final queue empty", fila.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/carregador_ram.md
# carregador_ram

Program loader that fills the processor's 16×8 RAM from the switch bank before execution. An operator starts a load, then presents one byte per strobe. The block writes each byte at an auto-incrementing address and flags completion so the processor can be released. It is the writer side of the RAM that the processor reads during execution.

## Interface
- ADDR_WIDTH, 4, RAM address width; depth = 2**ADDR_WIDTH (16)
- DATA_WIDTH, 8, RAM word width
- Clock  input  1  system clock; all state updates on rising edge
- Resetn  input  1  asynchronous, active-low reset
- Dados  input  DATA_WIDTH  byte to store (switches); must be stable while Strobe is high
- Strobe  input  1  raw asynchronous write request (key/switch); internally synchronized
- Inicio  input  1  synchronous one-cycle pulse: begin (or restart) a load at address 0
- Fim  input  1  level; if high when a strobe edge is detected, ends the load without writing
- MemQ  input  DATA_WIDTH  RAM read data, 1-cycle synchronous read latency (used only with verify)
- MemAddr  output  ADDR_WIDTH  RAM address
- MemData  output  DATA_WIDTH  RAM write data
- MemWrite  output  1  RAM write enable, one-cycle pulse
- Contagem  output  ADDR_WIDTH+1  number of words written in the current load (0..16)
- Ocupado  output  1  high in CARREGANDO and VERIFICANDO
- Pronto  output  1  high in CONCLUIDO; releases the processor
- Erro  output  1  sticky readback mismatch (verify build only; otherwise constant 0)

## Operation
- Reset: state OCIOSO. All outputs and the address counter are 0, as are the sync flops.
- Strobe passes through two flops (s1, s2) plus a previous-value flop. The edge is `s2 & ~prev`.
- OCIOSO: Inicio → CARREGANDO, counter = 0, Contagem = 0. Strobe edges are ignored.
- CARREGANDO, edge with Fim = 0:
  - register MemData = Dados and MemAddr = counter;
  - pulse MemWrite for one cycle;
  - increment Contagem.
  - After the write at address 15 (Contagem = 16), go to CONCLUIDO. Otherwise the counter increments and the state stays in CARREGANDO.
- CARREGANDO, edge with Fim = 1: go to CONCLUIDO with no write; Contagem is kept.
- CONCLUIDO: Pronto = 1.
  - Inicio → CARREGANDO, counter = 0, Contagem = 0, Erro cleared.
  - Strobe edges are ignored.
- Inicio during CARREGANDO restarts at address 0. Any write pulse already issued completes.
- If Inicio and an edge coincide, Inicio wins and the edge is dropped.
- The counter never wraps. A 17th write is impossible because the FSM leaves CARREGANDO after address 15.
- Resetn low at any time aborts the load immediately (asynchronous). No partial write pulse continues after reset.

## Timing
- Strobe first sampled high at edge k → edge detected at k+2 → MemWrite high for the cycle after edge k+2.
- MemAddr and MemData are valid in the same cycle as MemWrite and held until the next write or Inicio.
- Contagem updates on the same edge that raises MemWrite.
- Pronto rises one cycle after the final MemWrite cycle, or one cycle after the Fim edge.
- Minimum Strobe high and low time: 2 Clock cycles. Shorter pulses may be lost.
- One write per detected edge, so holding Strobe high yields exactly one write.

## Configuration
- CARREGADOR_VERIFICA_EN defined:
  - after each MemWrite cycle, the FSM enters VERIFICANDO for 2 cycles with MemAddr held;
  - MemQ is compared to MemData on the second edge; a mismatch sets Erro;
  - Erro stays set until Inicio or reset;
  - after verification the FSM returns to CARREGANDO, or goes to CONCLUIDO after address 15;
  - strobe edges detected in VERIFICANDO are dropped.
- Not defined: no VERIFICANDO state, MemQ ignored, Erro tied to 0.

## Structure
- Shared package carregador_pkg:
  - state encoding (OCIOSO, CARREGANDO, VERIFICANDO, CONCLUIDO);
  - default ADDR_WIDTH and DATA_WIDTH;
  - RAM depth constant.
- One sub-module: sincroniza_borda. It holds the 2-flop synchronizer and rising-edge detector, with async active-low reset. It is reused for other KEY/SW inputs.

## Test plan
- Reset, Inicio, then strobes with Dados = 0x10, 0x11 … 0x1F → sixteen MemWrite pulses at addresses 0..15, Contagem = 16, Pronto = 1 one cycle after the last write.
- Strobe edge at edge k → MemWrite exactly in the cycle after k+2. Strobe held high for 20 cycles → one write only.
- Three writes (0xA1, 0xB2, 0xC3), then a strobe with Fim = 1 → no 4th write, Contagem = 3, Pronto = 1.
- Strobe while OCIOSO or CONCLUIDO → no MemWrite. Inicio in CONCLUIDO → Contagem = 0, next write at address 0.
- Resetn low after 5 writes → all outputs 0 immediately. Strobes after release are ignored until Inicio.
- Verify build, MemQ forced to 0x00 after writing 0x5A → Erro = 1 and sticky through the remaining writes; next Inicio clears it.
